// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer: FSM state encoding and slot
// width. Imported by the sequencer top level.
package scan_sequencer_pkg;

    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the scan sequencer.
//   start, stop, mode, div : commands into the sequencer
//   a, b, en               : select/enable for the downstream 2x4 decoder
//   busy, slot_strobe, done: sequencer status
// master = controller side, slave = sequencer side.
interface scan_sequencer_if #(
    parameter int DIV_W = 16
) ();

    logic             start;
    logic             stop;
    logic             mode;
    logic [DIV_W-1:0] div;
    logic             a;
    logic             b;
    logic             en;
    logic             busy;
    logic             slot_strobe;
    logic             done;

    modport master (
        output start, stop, mode, div,
        input  a, b, en, busy, slot_strobe, done
    );

    modport slave (
        input  start, stop, mode, div,
        output a, b, en, busy, slot_strobe, done
    );

endinterface

// File: rtl/scan_down_counter.sv
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrementing saturates at zero.
//   clk, rst_n : clock, async active-low reset (count resets to 0)
//   load       : load load_val this cycle
//   load_val   : value to load
//   dec        : decrement by one when non-zero
//   count      : current value
//   zero       : count == 0
module scan_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: every flop here is small control state, so all of it is reset;
    // non-blocking assignments keep register updates order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Slot sequencer driving the select (a, b) and enable (en) of a 2x4 decoder.
// Steps slots 0..3, holds each enabled for div cycles, and separates slots
// with BLANK_CYCLES enable-low cycles. Continuous (mode=0) or single sweep
// (mode=1) with a done pulse; stop aborts to IDLE from any state.
//   clk, rst_n : clock, async active-low reset
//   bus        : scan_sequencer_if slave (commands in, decoder drive/status out)
// All outputs are registered.
import scan_sequencer_pkg::*;

module scan_sequencer #(
    parameter int DIV_W        = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_sequencer_if.slave   bus
);

    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD =
        (BLANK_CYCLES > 0) ? BLANK_W'(BLANK_CYCLES - 1) : '0;

    state_t           state_q, state_d;
    slot_t            slot_q, slot_d;
    logic             mode_q;
    logic [DIV_W-1:0] div_q;

    logic a_q, b_q, en_q, busy_q, strobe_q, done_q;
    logic en_d, busy_d, strobe_d, done_d;
    slot_t ab_d;

    logic [DIV_W-1:0]   dwell_cnt;
    logic [BLANK_W-1:0] blank_cnt;
    logic               dwell_zero, blank_zero;

    // div of 0 is treated as a one-cycle dwell
    logic [DIV_W-1:0] div_eff;
    assign div_eff = (bus.div == '0) ? DIV_W'(1) : bus.div;

    logic accept, dwell_end, advance, last_slot;
    assign accept    = (state_q == IDLE) && bus.start && !bus.stop;
    assign dwell_end = (state_q == DWELL) && dwell_zero;
    assign advance   = (BLANK_CYCLES == 0) ? dwell_end
                                           : ((state_q == BLANK) && blank_zero);
    assign last_slot = (slot_q == slot_t'(3)) && mode_q;

    scan_down_counter #(.W(DIV_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept || (advance && !last_slot)),
        .load_val (accept ? (div_eff - 1'b1) : (div_q - 1'b1)),
        .dec      (state_q == DWELL),
        .count    (dwell_cnt),
        .zero     (dwell_zero)
    );

    scan_down_counter #(.W(BLANK_W)) u_blank (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dwell_end && (BLANK_CYCLES > 0)),
        .load_val (BLANK_LOAD),
        .dec      (state_q == BLANK),
        .count    (blank_cnt),
        .zero     (blank_zero)
    );

    // State and latched-command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            mode_q  <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (accept) begin
                mode_q <= bus.mode;
                div_q  <= div_eff;
            end
        end
    end

    // Next-state logic
    // NOTE: every variable gets a default at the top of a combinational
    // block so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (bus.stop) begin
            state_d = IDLE;
            slot_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = DWELL;
                        slot_d  = '0;
                    end
                end
                DWELL: begin
                    if (dwell_zero && (BLANK_CYCLES > 0)) begin
                        state_d = BLANK;
                    end
                end
                default: ;
            endcase
            if (advance) begin
                if (last_slot) begin
                    state_d = IDLE;
                    slot_d  = '0;
                end else begin
                    state_d = DWELL;
                    slot_d  = slot_q + 1'b1;
                end
            end
        end
    end

    // Output logic: next values of the registered outputs, derived from the
    // next state so a/b only move on entry to DWELL or IDLE.
    always_comb begin
        en_d     = (state_d == DWELL);
        busy_d   = (state_d != IDLE);
        ab_d     = (state_d == IDLE) ? '0 : slot_d;
        strobe_d = !bus.stop && (accept || (advance && !last_slot));
        done_d   = !bus.stop && advance && last_slot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= ab_d[1];
            b_q      <= ab_d[0];
            en_q     <= en_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.en          = en_q;
    assign bus.busy        = busy_q;
    assign bus.slot_strobe = strobe_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer (BLANK_CYCLES=2). Expected
// per-cycle outputs come from an arithmetic waveform model and are queued
// before each sequence; outputs are sampled on the falling clock edge.
module tb_scan_sequencer;

    localparam int DIV_W = 16;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scan_sequencer_if #(.DIV_W(DIV_W)) bus ();

    scan_sequencer #(.DIV_W(DIV_W), .BLANK_CYCLES(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {decoded[3:0], a, b, en, busy, slot_strobe, done}
    typedef logic [9:0] obs_t;

    typedef struct {
        logic [DIV_W-1:0] div;
        logic             mode;
        int               dwell;
        int               period;
        int               ncyc;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];
    vec_t vecs[5];

    function automatic obs_t observe();
        logic [3:0] dec;
        dec = bus.en ? (4'b0001 << {bus.a, bus.b}) : 4'b0000;
        return {dec, bus.a, bus.b, bus.en, bus.busy, bus.slot_strobe, bus.done};
    endfunction

    // Expected outputs in cycle t after a start pulse in cycle 0.
    function automatic obs_t model(int t, int dwell, int period, bit single);
        int k, slot, phase;
        logic en;
        logic [1:0] s;
        logic [3:0] dec;
        if (t < 1) return '0;
        k = t - 1;
        if (single && k > 4 * period) return '0;
        if (single && k == 4 * period) return 10'b0000_000001;
        slot  = (k / period) % 4;
        phase = k % period;
        en    = (phase < dwell);
        s     = slot[1:0];
        dec   = en ? (4'b0001 << s) : 4'b0000;
        return {dec, s, en, 1'b1, (phase == 0), 1'b0};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got dec/a/b/en/busy/strb/done=%b, expected %b",
                     name, act, exp);
        end
    endtask

    // Called at posedge+1 of cycle 0 with the start pulse driven.
    task automatic kick(input logic [DIV_W-1:0] d, input logic m);
        bus.div   = d;
        bus.mode  = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Runs cycles 1..n, popping one expectation per cycle. stop is high in
    // cycle stop_at, start (with new div/mode) in cycle start_at.
    task automatic run(input string name, input int n, input int stop_at,
                       input int start_at, input logic [DIV_W-1:0] nd,
                       input logic nm);
        for (int t = 1; t <= n; t++) begin
            bus.stop  = (t == stop_at);
            bus.start = (t == start_at);
            if (t == start_at) begin
                bus.div  = nd;
                bus.mode = nm;
            end
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s: cycle %0d has no expected value queued", name, t);
            end else begin
                check($sformatf("%s c%0d", name, t), observe(), exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{div: 16'd3, mode: 1'b1, dwell: 3, period: 5, ncyc: 23};
        vecs[1] = '{div: 16'd1, mode: 1'b0, dwell: 1, period: 3, ncyc: 30};
        vecs[2] = '{div: 16'd0, mode: 1'b0, dwell: 1, period: 3, ncyc: 30};
        vecs[3] = '{div: 16'd0, mode: 1'b1, dwell: 1, period: 3, ncyc: 15};
        vecs[4] = '{div: 16'd5, mode: 1'b1, dwell: 5, period: 7, ncyc: 31};

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b1;
        bus.div   = 16'd3;

        // Reset held with a start pulse: everything stays 0
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("reset_hold", observe(), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        run("post_reset_idle", 3, 0, 0, 16'd3, 1'b1);

        // Table-driven sweeps, each ended by a stop
        for (int i = 0; i < 5; i++) begin
            for (int t = 1; t <= vecs[i].ncyc + 1; t++)
                exp_q.push_back(model(t, vecs[i].dwell, vecs[i].period, vecs[i].mode));
            exp_q.push_back('0);
            kick(vecs[i].div, vecs[i].mode);
            run($sformatf("vec%0d", i), vecs[i].ncyc + 2, vecs[i].ncyc + 1, 0,
                16'd0, 1'b0);
        end

        // start and stop in the same cycle: stays idle
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        run("start_stop", 3, 0, 0, 16'd3, 1'b1);

        // Abort in slot-1 DWELL (cycle 7): idle from cycle 8, no done
        for (int t = 1; t <= 7; t++) exp_q.push_back(model(t, 3, 5, 1'b1));
        for (int t = 8; t <= 24; t++) exp_q.push_back('0);
        kick(16'd3, 1'b1);
        run("abort", 24, 7, 0, 16'd3, 1'b1);

        // start (with different div/mode) while busy is ignored
        for (int t = 1; t <= 23; t++) exp_q.push_back(model(t, 3, 5, 1'b1));
        kick(16'd3, 1'b1);
        run("restart_busy", 23, 0, 7, 16'd1, 1'b0);

        // Asynchronous reset in BLANK (cycle 4), between clock edges
        kick(16'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_blank", observe(), model(4, 3, 5, 1'b1));
        #2 rst_n = 1'b0;
        #1 check("async_reset", observe(), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        run("after_async_reset", 3, 0, 0, 16'd3, 1'b1);

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0",
                     exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
